// File: rtl/video_test_pattern.sv
// -----------------------------------------------------------------------------
// video_test_pattern
//
// Purpose:
//   Generates one of four test patterns (colour bars, grid, gradient,
//   scrolling checker) in step with an external raster timing generator.
//   Active pixel/line counters and a frame counter are derived from the
//   blanking inputs. The pixel colour and the timing signals are registered
//   together, so R/G/B and the *_o timing outputs are mutually aligned one
//   ce_pix after the timing inputs were sampled.
//
// Parameters:
//   BAR_SHIFT  log2 of the colour-bar width in pixels (default 6 -> 64 px).
//              Must be <= 7 so the 3-bit bar index fits inside the 10-bit x.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous active-high reset
//   ce_pix     pixel clock enable; state only advances when it is high
//   HBlank, HSync, VBlank, VSync   raster timing inputs (active high)
//   mode[1:0]  pattern select: 0 bars, 1 grid, 2 gradient, 3 checker
//   ce_pix_o   ce_pix delayed by one clk (every clk, not gated)
//   HBlank_o, HSync_o, VBlank_o, VSync_o   timing aligned with R/G/B
//   R, G, B    8-bit pixel colour
//   x, y       10-bit active-pixel / active-line counters (saturating)
//   frame      8-bit frame counter (wrapping)
// -----------------------------------------------------------------------------
module video_test_pattern #(
    parameter int BAR_SHIFT = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       HBlank,
    input  logic       HSync,
    input  logic       VBlank,
    input  logic       VSync,
    input  logic [1:0] mode,
    output logic       ce_pix_o,
    output logic       HBlank_o,
    output logic       HSync_o,
    output logic       VBlank_o,
    output logic       VSync_o,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [7:0] frame
);

    localparam logic [9:0] COUNT_MAX = 10'h3FF;

    logic [1:0]  mode_q;
    logic        prev_hb;
    logic        prev_vb;

    logic        hb_rise;
    logic        vb_rise;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic [7:0]  frame_next;
    logic [1:0]  mode_next;

    logic [2:0]  bar_idx;
    logic [9:0]  scroll_sum;
    logic [23:0] bar_colour;
    logic [23:0] pattern_colour;
    logic [23:0] pixel_colour;

    // Edge detection against the values seen at the previous pixel enable,
    // so edges are measured in pixels rather than raw clocks.
    assign hb_rise = HBlank & ~prev_hb;
    assign vb_rise = VBlank & ~prev_vb;

    // Counter next-state. Vertical blanking clears y and takes priority over
    // the line increment that would otherwise happen on the HBlank edge.
    // The pattern mode is only sampled at the start of vertical blanking so
    // a frame never shows a mix of two patterns.
    always_comb begin
        x_next     = x;
        y_next     = y;
        frame_next = frame;
        mode_next  = mode_q;

        if (HBlank) begin
            x_next = 10'd0;
        end else if (x != COUNT_MAX) begin
            x_next = x + 10'd1;
        end

        if (VBlank) begin
            y_next = 10'd0;
        end else if (hb_rise && (y != COUNT_MAX)) begin
            y_next = y + 10'd1;
        end

        if (vb_rise) begin
            frame_next = frame + 8'd1;
            mode_next  = mode;
        end
    end

    assign bar_idx    = x[BAR_SHIFT+2:BAR_SHIFT];
    assign scroll_sum = x + {2'b00, frame};

    // Standard eight-bar sequence, brightest first, ending in black.
    always_comb begin
        bar_colour = 24'h000000;
        case (bar_idx)
            3'd0: bar_colour = 24'hFFFFFF;
            3'd1: bar_colour = 24'hFFFF00;
            3'd2: bar_colour = 24'h00FFFF;
            3'd3: bar_colour = 24'h00FF00;
            3'd4: bar_colour = 24'hFF00FF;
            3'd5: bar_colour = 24'hFF0000;
            3'd6: bar_colour = 24'h0000FF;
            3'd7: bar_colour = 24'h000000;
            default: bar_colour = 24'h000000;
        endcase
    end

    // Pattern selection uses the counter values before this pixel's update,
    // i.e. the position of the pixel currently being presented.
    always_comb begin
        pattern_colour = 24'h000000;
        case (mode_q)
            2'd0: pattern_colour = bar_colour;
            2'd1: begin
                if ((x[3:0] == 4'd0) || (y[3:0] == 4'd0)) begin
                    pattern_colour = 24'hFFFFFF;
                end else begin
                    pattern_colour = 24'h202020;
                end
            end
            2'd2: pattern_colour = {x[7:0], y[7:0], frame};
            2'd3: begin
                if (scroll_sum[3] ^ y[3]) begin
                    pattern_colour = 24'hFFFFFF;
                end else begin
                    pattern_colour = 24'h000000;
                end
            end
            default: pattern_colour = 24'h000000;
        endcase
    end

    // Blanking always produces black regardless of pattern.
    always_comb begin
        pixel_colour = pattern_colour;
        if (HBlank || VBlank) begin
            pixel_colour = 24'h000000;
        end
    end

    // ce_pix_o runs every clock so downstream logic sees the enable aligned
    // with the registered pixel data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_pix_o <= 1'b0;
        end else begin
            ce_pix_o <= ce_pix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x        <= 10'd0;
            y        <= 10'd0;
            frame    <= 8'd0;
            mode_q   <= 2'd0;
            prev_hb  <= 1'b0;
            prev_vb  <= 1'b0;
            HBlank_o <= 1'b0;
            HSync_o  <= 1'b0;
            VBlank_o <= 1'b0;
            VSync_o  <= 1'b0;
            R        <= 8'd0;
            G        <= 8'd0;
            B        <= 8'd0;
        end else if (ce_pix) begin
            x        <= x_next;
            y        <= y_next;
            frame    <= frame_next;
            mode_q   <= mode_next;
            prev_hb  <= HBlank;
            prev_vb  <= VBlank;
            HBlank_o <= HBlank;
            HSync_o  <= HSync;
            VBlank_o <= VBlank;
            VSync_o  <= VSync;
            R        <= pixel_colour[23:16];
            G        <= pixel_colour[15:8];
            B        <= pixel_colour[7:0];
        end
    end

endmodule

// File: tb/tb_video_test_pattern.sv
// -----------------------------------------------------------------------------
// tb_video_test_pattern
//
// Drives video_test_pattern from a simple raster generator (configurable
// line/frame geometry, optional random pixel-enable gaps, mid-frame mode
// changes, a mid-line reset and a 10-clock enable stall) and compares every
// clock against a behavioural model of the pattern rules.
// -----------------------------------------------------------------------------
module tb_video_test_pattern;

    localparam int BAR_W = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic       HBlank;
    logic       HSync;
    logic       VBlank;
    logic       VSync;
    logic [1:0] mode;
    logic       ce_pix_o;
    logic       HBlank_o;
    logic       HSync_o;
    logic       VBlank_o;
    logic       VSync_o;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] frame;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state
    int          m_x, m_y, m_frame, m_mode;
    bit          m_prev_hb, m_prev_vb;
    logic [23:0] m_rgb;
    bit          m_hb_o, m_hs_o, m_vb_o, m_vs_o, m_ce_o;

    // Pre-update view of the last enabled pixel, for directed checks
    int last_x, last_y, last_frame, last_mode;
    bit last_blank, last_hb, last_vb_rise;

    // Stimulus controls
    int pix_count   = 0;
    int reset_at    = -1;
    int stall_at    = -1;
    bit random_stall = 1'b0;
    bit grad_seen   = 1'b0;
    bit wrap_seen   = 1'b0;
    bit sat_seen    = 1'b0;

    video_test_pattern #(.BAR_SHIFT(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .HBlank   (HBlank),
        .HSync    (HSync),
        .VBlank   (VBlank),
        .VSync    (VSync),
        .mode     (mode),
        .ce_pix_o (ce_pix_o),
        .HBlank_o (HBlank_o),
        .HSync_o  (HSync_o),
        .VBlank_o (VBlank_o),
        .VSync_o  (VSync_o),
        .R        (R),
        .G        (G),
        .B        (B),
        .x        (x),
        .y        (y),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL timeout: actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Pattern colour from position, frame and mode, written from the
    // pattern definitions with ordinary arithmetic.
    function automatic logic [23:0] refColour(input int px, input int py,
                                              input int pf, input int pm);
        logic [23:0] bars [8];
        int s;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        case (pm)
            0: return bars[(px / BAR_W) % 8];
            1: return ((px % 16 == 0) || (py % 16 == 0)) ? 24'hFFFFFF : 24'h202020;
            2: return {8'(px % 256), 8'(py % 256), 8'(pf % 256)};
            default: begin
                s = (px + pf) % 1024;
                return (((s / 8) % 2) != ((py / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
            end
        endcase
    endfunction

    task automatic modelReset();
        m_x = 0; m_y = 0; m_frame = 0; m_mode = 0;
        m_prev_hb = 0; m_prev_vb = 0; m_rgb = 24'h0;
        m_hb_o = 0; m_hs_o = 0; m_vb_o = 0; m_vs_o = 0; m_ce_o = 0;
    endtask

    task automatic modelClock(input bit ce, input bit hb, input bit hs,
                              input bit vb, input bit vs, input int md);
        m_ce_o = ce;
        if (ce) begin
            last_x = m_x; last_y = m_y; last_frame = m_frame; last_mode = m_mode;
            last_blank = hb || vb;
            last_hb = hb;
            last_vb_rise = vb && !m_prev_vb;
            m_rgb = last_blank ? 24'h000000 : refColour(m_x, m_y, m_frame, m_mode);
            m_hb_o = hb; m_hs_o = hs; m_vb_o = vb; m_vs_o = vs;
            if (vb && !m_prev_vb) begin
                m_frame = (m_frame + 1) % 256;
                m_mode  = md;
            end
            if (vb) m_y = 0;
            else if (hb && !m_prev_hb) m_y = (m_y < 1023) ? m_y + 1 : 1023;
            m_x = hb ? 0 : ((m_x < 1023) ? m_x + 1 : 1023);
            m_prev_hb = hb;
            m_prev_vb = vb;
        end
    endtask

    task automatic compareAll();
        checkOutput("rgb", 32'({R, G, B}), 32'(m_rgb));
        checkOutput("x", 32'(x), 32'(m_x));
        checkOutput("y", 32'(y), 32'(m_y));
        checkOutput("frame", 32'(frame), 32'(m_frame));
        checkOutput("timing", 32'({HBlank_o, HSync_o, VBlank_o, VSync_o}),
                    32'({m_hb_o, m_hs_o, m_vb_o, m_vs_o}));
        checkOutput("ce_pix_o", 32'(ce_pix_o), 32'(m_ce_o));
    endtask

    task automatic directedChecks(input bit ce);
        if (!ce) begin
            checkOutput("stall_ce_o", 32'(ce_pix_o), 32'd0);
            return;
        end
        if (last_blank) begin
            checkOutput("blank_rgb", 32'({R, G, B}), 32'h0);
        end else begin
            if (last_mode == 0 && last_x < 64)
                checkOutput("bar0", 32'({R, G, B}), 32'hFFFFFF);
            if (last_mode == 0 && last_x == 64)
                checkOutput("bar1_start", 32'({R, G, B}), 32'hFFFF00);
            if (last_mode == 0 && last_x >= 448 && last_x <= 511)
                checkOutput("bar7", 32'({R, G, B}), 32'h000000);
            if (last_mode == 1 && last_x == 1 && last_y == 1)
                checkOutput("grid_fill", 32'({R, G, B}), 32'h202020);
            if (last_mode == 2 && last_x == 300 && last_y == 5 && last_frame == 3) begin
                checkOutput("grad_x300_y5_f3", 32'({R, G, B}), 32'h2C0503);
                grad_seen = 1'b1;
            end
        end
        if (!last_hb && last_x == 1023) begin
            checkOutput("x_sat", 32'(x), 32'd1023);
            sat_seen = 1'b1;
        end
        if (last_vb_rise && last_frame == 255) begin
            checkOutput("frame_wrap", 32'(frame), 32'd0);
            wrap_seen = 1'b1;
        end
    endtask

    task automatic oneClock(input bit ce);
        ce_pix = ce;
        @(posedge clk);
        modelClock(ce, HBlank, HSync, VBlank, VSync, int'(mode));
        #1;
        compareAll();
        directedChecks(ce);
    endtask

    // Present one pixel of timing, with any scheduled reset or stall.
    task automatic applyStimulus(input bit hb, input bit hs, input bit vb, input bit vs);
        HBlank = hb; HSync = hs; VBlank = vb; VSync = vs;
        if (pix_count == reset_at) begin
            reset = 1'b1;
            #1;
            checkOutput("rst_rgb", 32'({R, G, B}), 32'h0);
            checkOutput("rst_x", 32'(x), 32'd0);
            checkOutput("rst_y", 32'(y), 32'd0);
            checkOutput("rst_frame", 32'(frame), 32'd0);
            checkOutput("rst_hsync_o", 32'(HSync_o), 32'd0);
            checkOutput("rst_ce_pix_o", 32'(ce_pix_o), 32'd0);
            modelReset();
            #1;
            reset = 1'b0;
        end
        if (pix_count == stall_at) begin
            repeat (10) oneClock(1'b0);
        end else if (random_stall && $urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(1, 2)) oneClock(1'b0);
        end
        oneClock(1'b1);
        pix_count++;
    endtask

    task automatic runFrame(input int h_act, input int h_bl, input int v_act,
                            input int v_bl, input int new_mode, input int change_line);
        for (int line = 0; line < v_act + v_bl; line++) begin
            for (int p = 0; p < h_act + h_bl; p++) begin
                if (line == change_line && p == h_act / 2) mode = 2'(new_mode);
                applyStimulus(p >= h_act,
                              (p >= h_act + 1) && (p < h_act + 3),
                              line >= v_act,
                              line == v_act);
            end
        end
    endtask

    initial begin
        reset = 1'b1; ce_pix = 1'b0; mode = 2'd0;
        HBlank = 1'b0; HSync = 1'b0; VBlank = 1'b0; VSync = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        checkOutput("init_rgb", 32'({R, G, B}), 32'h0);
        checkOutput("init_xyf", 32'({x, y, frame}), 32'h0);
        checkOutput("init_timing", 32'({ce_pix_o, HBlank_o, HSync_o, VBlank_o, VSync_o}), 32'h0);
        reset = 1'b0;

        // Bars with a continuous enable, a mid-line reset and a long stall
        reset_at = 1 * 624 + 200;
        stall_at = 3 * 624 + 300;
        runFrame(600, 24, 8, 2, 0, -1);
        // Mode switched to grid mid-frame: bars must persist to frame end
        runFrame(600, 24, 8, 2, 1, 3);
        random_stall = 1'b1;
        runFrame(600, 24, 8, 2, 2, 0);
        runFrame(600, 24, 8, 2, 3, 0);
        // Over-long line exercises x saturation
        runFrame(1100, 24, 3, 2, int'($urandom_range(0, 3)), 1);
        // Short frames until the frame counter wraps
        for (int f = 0; f < 270; f++) begin
            runFrame(8, 4, 2, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        checkOutput("grad_point_seen", 32'(grad_seen), 32'd1);
        checkOutput("frame_wrap_seen", 32'(wrap_seen), 32'd1);
        checkOutput("x_sat_seen", 32'(sat_seen), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
